csr_seq: RTL

Multi-cycle CSR instruction sequencer between the ID stage and the `csr` register unit. It accepts one decoded CSR/ECALL/MRET instruction per handshake and drives the `csr` unit's read, write and state controls in separate cycles. For CSRRW/RS/RC and the immediate forms it performs the read-modify-write. It returns the rd writeback value, or the trap/return redirect PC, to the downstream stage through a valid/ready handshake.

---
 rtl/csr_seq.sv | 203 ++++++++++++++++++++
 1 files changed

// File: rtl/csr_seq.sv
// csr_seq: multi-cycle CSR instruction sequencer between ID and the csr unit.
// Each accepted instruction walks IDLE -> (READ -> WRITE | TRAP) -> DONE and
// issues at most one read, one write and one state pulse to the csr unit.
module csr_seq #(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            rst_n,
  // instruction from ID
  input  logic            in_valid_i,
  output logic            in_ready_o,
  input  logic [2:0]      in_funct3_i,
  input  logic [11:0]     in_csr_addr_i,
  input  logic [4:0]      in_rs1_idx_i,
  input  logic [XLEN-1:0] in_rs1_data_i,
  input  logic [4:0]      in_rd_i,
  input  logic [XLEN-1:0] in_pc_i,
  input  logic            in_ecall_i,
  input  logic            in_mret_i,
  // csr unit controls
  output logic [1:0]      csr_state_o,
  output logic [11:0]     csr_r_addr_o,
  output logic [11:0]     csr_w_addr_o,
  output logic            csr_ren_o,
  output logic            csr_wen_o,
  output logic [XLEN-1:0] csr_w_data_o,
  output logic [XLEN-1:0] csr_pc_o,
  input  logic [XLEN-1:0] csr_r_data_i,
  input  logic [XLEN-1:0] csr_dnpc_i,
  // result to downstream
  output logic            out_valid_o,
  input  logic            out_ready_i,
  output logic            out_wb_en_o,
  output logic [4:0]      out_rd_o,
  output logic [XLEN-1:0] out_wb_data_o,
  output logic            out_redirect_o,
  output logic [XLEN-1:0] out_redirect_pc_o,
  output logic            out_illegal_o
);

  localparam logic [1:0] CSR_STATE_NONE  = 2'b00;
  localparam logic [1:0] CSR_STATE_RW    = 2'b01;
  localparam logic [1:0] CSR_STATE_ECALL = 2'b10;
  localparam logic [1:0] CSR_STATE_MRET  = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_WRITE,
    S_TRAP,
    S_DONE
  } state_t;

  state_t state_reg, state_next;

  // latched instruction fields
  logic [2:0]      funct3_reg;
  logic [11:0]     addr_reg;
  logic [4:0]      rs1_idx_reg;
  logic [XLEN-1:0] rs1_data_reg;
  logic [4:0]      rd_reg;
  logic [XLEN-1:0] pc_reg;
  logic            ecall_reg;
  logic [XLEN-1:0] new_data_reg;

  // result registers
  logic            wb_en_reg;
  logic [XLEN-1:0] wb_data_reg;
  logic            redirect_reg;
  logic [XLEN-1:0] redirect_pc_reg;
  logic            illegal_reg;

  logic            accept;
  logic            in_legal;
  logic [XLEN-1:0] src;
  logic [XLEN-1:0] new_data;
  logic            write_allowed;

  assign accept   = in_valid_i && (state_reg == S_IDLE);
  // funct3 low bits of 00 (000/100) are not CSR ops
  assign in_legal = (in_funct3_i[1:0] != 2'b00);

  // Operand select and read-modify-write value, based on the captured old value
  always_comb begin
    src      = funct3_reg[2] ? {{(XLEN-5){1'b0}}, rs1_idx_reg} : rs1_data_reg;
    new_data = src;
    case (funct3_reg[1:0])
      2'b10:   new_data = csr_r_data_i | src;
      2'b11:   new_data = csr_r_data_i & ~src;
      default: new_data = src;
    endcase
  end

  // Set/clear forms with x0/zimm=0 must not write (no side effects)
  assign write_allowed = (funct3_reg[1:0] == 2'b01) || (rs1_idx_reg != 5'd0);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= S_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state selection
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE: begin
        if (in_valid_i) begin
          if (in_ecall_i || in_mret_i) state_next = S_TRAP;
          else if (in_legal)           state_next = S_READ;
          else                         state_next = S_DONE;
        end
      end
      S_READ:  state_next = S_WRITE;
      S_WRITE: state_next = S_DONE;
      S_TRAP:  state_next = S_DONE;
      S_DONE:  if (out_ready_i) state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // csr unit strobes, decoded from state so a reset kills them immediately
  always_comb begin
    csr_ren_o   = 1'b0;
    csr_wen_o   = 1'b0;
    csr_state_o = CSR_STATE_NONE;
    case (state_reg)
      S_READ:  csr_ren_o = 1'b1;
      S_WRITE: begin
        csr_state_o = CSR_STATE_RW;
        csr_wen_o   = write_allowed;
      end
      S_TRAP:  csr_state_o = ecall_reg ? CSR_STATE_ECALL : CSR_STATE_MRET;
      default: ;
    endcase
  end

  // Instruction latch and result capture
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      funct3_reg      <= '0;
      addr_reg        <= '0;
      rs1_idx_reg     <= '0;
      rs1_data_reg    <= '0;
      rd_reg          <= '0;
      pc_reg          <= '0;
      ecall_reg       <= 1'b0;
      new_data_reg    <= '0;
      wb_en_reg       <= 1'b0;
      wb_data_reg     <= '0;
      redirect_reg    <= 1'b0;
      redirect_pc_reg <= '0;
      illegal_reg     <= 1'b0;
    end else begin
      case (state_reg)
        S_IDLE: begin
          if (accept) begin
            funct3_reg      <= in_funct3_i;
            addr_reg        <= in_csr_addr_i;
            rs1_idx_reg     <= in_rs1_idx_i;
            rs1_data_reg    <= in_rs1_data_i;
            rd_reg          <= in_rd_i;
            pc_reg          <= in_pc_i;
            // ECALL wins when both trap flags are set
            ecall_reg       <= in_ecall_i;
            wb_en_reg       <= 1'b0;
            wb_data_reg     <= '0;
            redirect_reg    <= 1'b0;
            redirect_pc_reg <= '0;
            illegal_reg     <= !in_ecall_i && !in_mret_i && !in_legal;
          end
        end
        S_READ: begin
          wb_data_reg  <= csr_r_data_i;
          new_data_reg <= new_data;
          wb_en_reg    <= (rd_reg != 5'd0);
        end
        S_TRAP: begin
          redirect_reg    <= 1'b1;
          redirect_pc_reg <= csr_dnpc_i;
        end
        default: ;
      endcase
    end
  end

  assign in_ready_o        = (state_reg == S_IDLE);
  assign out_valid_o       = (state_reg == S_DONE);
  assign csr_r_addr_o      = addr_reg;
  assign csr_w_addr_o      = addr_reg;
  assign csr_w_data_o      = new_data_reg;
  assign csr_pc_o          = pc_reg;
  assign out_wb_en_o       = wb_en_reg;
  assign out_rd_o          = rd_reg;
  assign out_wb_data_o     = wb_data_reg;
  assign out_redirect_o    = redirect_reg;
  assign out_redirect_pc_o = redirect_pc_reg;
  assign out_illegal_o     = illegal_reg;

endmodule
